// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle HI/LO multiply/divide sequencer (shift-add multiply, restoring divide)
module muldiv_seq (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [5:0]  funct_i,
  input  logic [31:0] rdata1_i,
  input  logic [31:0] rdata2_i,
  input  logic        kill_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        done_o
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [5:0] F_MTHI = 6'h11;
  localparam logic [5:0] F_MTLO = 6'h13;
  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] w_q, w_d;
  logic [31:0] m_q, m_d, a_q, a_d, hi_q, hi_d, lo_q, lo_d;
  logic        div_q, div_d, sgn_q, sgn_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, done_q, done_d;
  logic        is_md, sgn_in, ge;
  logic [31:0] ma, mb, sub, q_fix, r_fix, dz_lo;
  logic [32:0] madd;
  logic [63:0] w_step, prod;
  assign is_md  = funct_i[5:2] == 4'b0110;
  assign sgn_in = is_md & ~funct_i[0];
  assign ma     = (sgn_in && rdata1_i[31]) ? -rdata1_i : rdata1_i;
  assign mb     = (sgn_in && rdata2_i[31]) ? -rdata2_i : rdata2_i;
  // multiply step: conditional add into the upper half, then shift the pair right
  assign madd   = {1'b0, w_q[63:32]} + (w_q[0] ? {1'b0, m_q} : 33'd0);
  // divide step: the shifted partial remainder is 33 bits; only its low 32 survive a successful subtract
  assign ge     = w_q[63:31] >= {1'b0, m_q};
  assign sub    = w_q[62:31] - m_q;
  assign w_step = div_q ? {ge ? sub : w_q[62:31], w_q[30:0], ge} : {madd, w_q[31:1]};
  assign prod   = neg_lo_q ? -w_q : w_q;
  assign q_fix  = neg_lo_q ? -w_q[31:0] : w_q[31:0];
  assign r_fix  = neg_hi_q ? -w_q[63:32] : w_q[63:32];
  assign dz_lo  = (sgn_q && a_q[31]) ? 32'h1 : 32'hFFFF_FFFF;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = state_q != S_IDLE;
  assign done_o = done_q;
  // next-state: accept/move-to in IDLE, iterate in CALC, sign-fix and commit in FIX
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_d      = w_q;
    m_d      = m_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div_d    = div_q;
    sgn_d    = sgn_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: if (start_i && !kill_i) begin
        hi_d = funct_i == F_MTHI ? rdata2_i : hi_q;
        lo_d = funct_i == F_MTLO ? rdata2_i : lo_q;
        if (is_md) begin
          state_d  = S_CALC;
          cnt_d    = 6'd0;
          div_d    = funct_i[1];
          sgn_d    = sgn_in;
          w_d      = {32'd0, funct_i[1] ? ma : mb};
          m_d      = funct_i[1] ? mb : ma;
          a_d      = rdata1_i;
          neg_lo_d = sgn_in & (rdata1_i[31] ^ rdata2_i[31]);
          neg_hi_d = sgn_in & rdata1_i[31];
        end
      end
      S_CALC: begin
        state_d = kill_i ? S_IDLE : (cnt_q == 6'd31 ? S_FIX : S_CALC);
        w_d     = kill_i ? w_q : w_step;
        cnt_d   = kill_i ? cnt_q : cnt_q + 6'd1;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = !kill_i;
        hi_d    = kill_i ? hi_q : (!div_q ? prod[63:32] : (m_q == 32'd0 ? a_q : r_fix));
        lo_d    = kill_i ? lo_q : (!div_q ? prod[31:0] : (m_q == 32'd0 ? dz_lo : q_fix));
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state registers with asynchronous active-low clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      w_q      <= 64'd0;
      m_q      <= 32'd0;
      a_q      <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      div_q    <= 1'b0;
      sgn_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      w_q      <= w_d;
      m_q      <= m_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      div_q    <= div_d;
      sgn_q    <= sgn_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      done_q   <= done_d;
    end
  end
endmodule
